// File: rtl/cpu_sched_pkg.sv
// Shared types and constants for the issue scoreboard.
// The countdown field is sized for the largest supported LAT_W (LAT_W_MAX).
// Entries built with a smaller LAT_W keep the unused upper bits at zero.
package cpu_sched_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int LAT_W_DEF      = 3;
  localparam int LAT_W_MAX      = 8;

  // Architectural x0: never tracked, writes to it are dropped.
  localparam int REG_ZERO = 0;

  typedef logic [LAT_W_MAX-1:0] sb_cnt_t;

  typedef struct packed {
    logic    pending;
    logic    wait_wb;
    sb_cnt_t cnt;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_entry.sv
// State for one tracked destination register.
// A fixed-latency result counts down to zero, stays visible (forwardable) for
// one more cycle, then retires. A variable-latency result waits for a matching
// write-back; that path exists only when SCOREBOARD_WB_TRACK_EN is defined.
// Without it, a latency of 0 is treated as 1.
module scoreboard_entry
  import cpu_sched_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [LAT_W-1:0] load_latency,
  input  logic             wb_hit,
  output logic             pending,
  output logic             busy
);

  sb_entry_t ent;

`ifndef SCOREBOARD_WB_TRACK_EN
  logic unused_wb_hit;
  assign unused_wb_hit = wb_hit;
`endif

  // Load on issue (new issue wins over retirement), otherwise count down/retire.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ent <= '0;
    end else if (enable) begin
      if (load) begin
        ent.pending <= 1'b1;
`ifdef SCOREBOARD_WB_TRACK_EN
        if (load_latency == '0) begin
          ent.wait_wb <= 1'b1;
          ent.cnt     <= '0;
        end else begin
          ent.wait_wb <= 1'b0;
          ent.cnt     <= sb_cnt_t'(load_latency);
        end
`else
        ent.wait_wb <= 1'b0;
        ent.cnt     <= (load_latency == '0) ? sb_cnt_t'(1) : sb_cnt_t'(load_latency);
`endif
      end else if (ent.pending && !ent.wait_wb) begin
        if (ent.cnt != '0) begin
          ent.cnt <= ent.cnt - sb_cnt_t'(1);
        end else begin
          ent.pending <= 1'b0;
        end
      end
`ifdef SCOREBOARD_WB_TRACK_EN
      else if (ent.pending && ent.wait_wb && wb_hit) begin
        ent.pending <= 1'b0;
        ent.wait_wb <= 1'b0;
      end
`endif
    end
  end

  assign pending = ent.pending;
  // Readers must wait while the value is still being produced.
  assign busy    = ent.pending & ((ent.cnt != '0) | ent.wait_wb);

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard between ID and EX.
// Tracks every in-flight destination register, stalls issue on RAW/WAW
// hazards and suppresses issue on flush. Keeps a saturating stall counter.
// Optional feature macro: SCOREBOARD_WB_TRACK_EN enables variable-latency
// tracking (issue_latency==0 waits for wb_valid/wb_rd). When undefined, the
// write-back inputs are ignored and latency 0 behaves as latency 1.
module issue_scoreboard
  import cpu_sched_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int LAT_W       = LAT_W_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     enable,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_W-1:0]    issue_rs1,
  input  logic [REG_ADDR_W-1:0]    issue_rs2,
  input  logic                     issue_rs1_used,
  input  logic                     issue_rs2_used,
  input  logic [REG_ADDR_W-1:0]    issue_rd,
  input  logic                     issue_rd_wen,
  input  logic [LAT_W-1:0]         issue_latency,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  output logic                     issue_stall,
  output logic                     issue_fire,
  output logic [2**REG_ADDR_W-1:0] pending_mask,
  output logic [REG_ADDR_W:0]      inflight_cnt,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  localparam int NREG = 2**REG_ADDR_W;

  logic [NREG-1:0]     pend_vec;
  logic [NREG-1:0]     busy_vec;
  logic                wb_act;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic [REG_ADDR_W:0] popcnt;

`ifdef SCOREBOARD_WB_TRACK_EN
  assign wb_act = wb_valid;
`else
  assign wb_act = 1'b0;
  logic unused_wb_valid;
  assign unused_wb_valid = wb_valid;
`endif

  // x0 is hard-wired idle.
  assign pend_vec[REG_ZERO] = 1'b0;
  assign busy_vec[REG_ZERO] = 1'b0;

  for (genvar r = REG_ZERO + 1; r < NREG; r++) begin : g_entry
    scoreboard_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk         (clk),
      .arst_n      (arst_n),
      .enable      (enable),
      .load        (issue_fire & issue_rd_wen & (issue_rd == REG_ADDR_W'(r))),
      .load_latency(issue_latency),
      .wb_hit      (wb_act & (wb_rd == REG_ADDR_W'(r))),
      .pending     (pend_vec[r]),
      .busy        (busy_vec[r])
    );
  end

  // A same-cycle write-back to the register resolves the hazard via WB forwarding.
  assign raw1 = issue_rs1_used & busy_vec[issue_rs1] & ~(wb_act & (wb_rd == issue_rs1));
  assign raw2 = issue_rs2_used & busy_vec[issue_rs2] & ~(wb_act & (wb_rd == issue_rs2));
  assign waw  = issue_rd_wen & pend_vec[issue_rd] & ~(wb_act & (wb_rd == issue_rd));

  assign issue_stall = issue_valid & (raw1 | raw2 | waw) & ~flush;
  assign issue_fire  = enable & issue_valid & ~issue_stall & ~flush;

  assign pending_mask = pend_vec;

  // Population count of outstanding registers.
  always_comb begin
    popcnt = '0;
    for (int i = 0; i < NREG; i++) begin
      popcnt = popcnt + {{REG_ADDR_W{1'b0}}, pend_vec[i]};
    end
  end

  assign inflight_cnt = popcnt;

  // Saturating count of enabled cycles spent stalled.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      stall_cycles <= '0;
    end else if (enable && issue_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a table of per-cycle vectors with
// expected outputs queued when driven and compared when sampled, plus a
// hand-written long WAW stall sequence that also saturates a narrow counter.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_rs1_used;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_wen;
  logic [2:0]  issue_latency;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue_stall;
  logic        issue_fire;
  logic [31:0] pending_mask;
  logic [5:0]  inflight_cnt;
  logic [31:0] stall_cycles;

  logic        sat_unused_stall;
  logic        sat_unused_fire;
  logic [31:0] sat_unused_mask;
  logic [5:0]  sat_unused_infl;
  logic [2:0]  sat_stall_cycles;

  always #5 clk = ~clk;

  issue_scoreboard u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_latency(issue_latency),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_stall(issue_stall), .issue_fire(issue_fire), .pending_mask(pending_mask),
    .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles)
  );

  issue_scoreboard #(.STALL_CNT_W(3)) u_sat (
    .clk(clk), .arst_n(arst_n), .enable(enable), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_latency(issue_latency),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_stall(sat_unused_stall), .issue_fire(sat_unused_fire),
    .pending_mask(sat_unused_mask), .inflight_cnt(sat_unused_infl),
    .stall_cycles(sat_stall_cycles)
  );

  typedef struct {
    logic        en, rstn, v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  lat;
    logic        fl, wbv;
    logic [4:0]  wbrd;
    logic        e_stall, e_fire;
    logic [31:0] e_mask;
    logic [31:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
    end
  endtask

  function automatic logic [31:0] b(input int r);
    return 32'd1 << r;
  endfunction

  // en rstn v rs1 u1 rs2 u2 rd wen lat fl wbv wbrd | stall fire mask stall_cycles
  function automatic void add(input int en, input int rstn, input int v, input int rs1, input int u1,
                              input int rs2, input int u2, input int rd, input int wen, input int lat,
                              input int fl, input int wbv, input int wbrd, input int es, input int ef,
                              input logic [31:0] mask, input int sc);
    vec_t r;
    r.en = 1'(en); r.rstn = 1'(rstn); r.v = 1'(v);
    r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
    r.rd = 5'(rd); r.wen = 1'(wen); r.lat = 3'(lat);
    r.fl = 1'(fl); r.wbv = 1'(wbv); r.wbrd = 5'(wbrd);
    r.e_stall = 1'(es); r.e_fire = 1'(ef); r.e_mask = mask; r.e_sc = 32'(sc);
    vecs.push_back(r);
  endfunction

  function automatic void idle(input logic [31:0] mask, input int sc);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mask, sc);
  endfunction

  task automatic drive_idle();
    enable = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
    issue_rs1_used = 1'b0; issue_rs2_used = 1'b0; issue_rd = '0; issue_rd_wen = 1'b0;
    issue_latency = '0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
  endtask

  initial begin
    int   stalls;
    logic fired;

    // Reset state
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Latency 1 producer rd=5, dependent rs1=5
    add(1, 1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(5), 0);
    add(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(5), 1);
    idle(0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Latency 3 producer rd=7, dependent rs2=7: three stall cycles
    add(1, 1, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, b(7), 0);
    add(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, b(7), 1);
    add(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, b(7), 2);
    add(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, b(7), 3);
    idle(0, 3);
    // WAW on rd=4 until the entry retires
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 2, 0, 0, 0, 0, 1, 0, 3);
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, b(4), 3);
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, b(4), 4);
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 0, b(4), 5);
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 1, 0, 6);
    idle(b(4), 6);
    idle(b(4), 6);
    idle(0, 6);
    // Flush over a hazard, then an rd=0 write
    add(1, 1, 1, 0, 0, 0, 0, 10, 1, 3, 0, 0, 0, 0, 1, 0, 6);
    add(1, 1, 1, 10, 1, 0, 0, 11, 1, 1, 1, 0, 0, 0, 0, b(10), 6);
    add(1, 1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, b(10), 6);
    idle(b(10), 6);
    idle(b(10), 6);
    idle(0, 6);
    // enable=0 freezes state but stall is still computed
    add(1, 1, 1, 0, 0, 0, 0, 12, 1, 2, 0, 0, 0, 0, 1, 0, 6);
    add(1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(12), 6);
    add(0, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(12), 7);
    add(0, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(12), 7);
    add(0, 1, 1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, b(12), 7);
    add(1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(12), 7);
    add(1, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(12), 8);
    idle(0, 8);
    // Reset with three entries outstanding
    add(1, 1, 1, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, 1, 0, 8);
    add(1, 1, 1, 0, 0, 0, 0, 2, 1, 7, 0, 0, 0, 0, 1, b(1), 8);
    add(1, 1, 1, 0, 0, 0, 0, 3, 1, 7, 0, 0, 0, 0, 1, b(1) | b(2), 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, b(1) | b(2) | b(3), 8);
    idle(0, 0);
`ifdef SCOREBOARD_WB_TRACK_EN
    // Variable latency rd=9 released by same-cycle write-back
    add(1, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(9), 0);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, b(9), 1);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, b(9), 2);
    idle(0, 2);
    // Same-cycle wb of 4 and new issue to 4: issue wins
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 2);
    add(1, 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 4, 0, 1, b(4), 2);
    idle(b(4), 2);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, b(4), 2);
    idle(0, 2);
`else
    // Latency 0 acts as 1; write-back inputs have no effect
    add(1, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, b(9), 0);
    add(1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(9), 1);
    idle(0, 1);
`endif

    drive_idle();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r;
      vec_t e;
      r = vecs[i];
      enable = r.en; arst_n = r.rstn; issue_valid = r.v;
      issue_rs1 = r.rs1; issue_rs1_used = r.u1; issue_rs2 = r.rs2; issue_rs2_used = r.u2;
      issue_rd = r.rd; issue_rd_wen = r.wen; issue_latency = r.lat;
      flush = r.fl; wb_valid = r.wbv; wb_rd = r.wbrd;
      exp_q.push_back(r);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("issue_stall", i, 64'(issue_stall), 64'(e.e_stall));
      chk("issue_fire", i, 64'(issue_fire), 64'(e.e_fire));
      chk("pending_mask", i, 64'(pending_mask), 64'(e.e_mask));
      chk("inflight_cnt", i, 64'(inflight_cnt), 64'($countones(e.e_mask)));
      chk("stall_cycles", i, 64'(stall_cycles), 64'(e.e_sc));
      @(posedge clk);
      #1;
    end

    // Long WAW stall: 8 stall cycles saturate the 3-bit counter at 7
    drive_idle();
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("seq_reset_sc", 1000, 64'(stall_cycles), 64'd0);
    chk("seq_reset_sat", 1000, 64'(sat_stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    issue_valid = 1'b1; issue_rd = 5'd20; issue_rd_wen = 1'b1; issue_latency = 3'd7;
    @(negedge clk);
    chk("seq_first_fire", 1001, 64'(issue_fire), 64'd1);
    @(posedge clk);
    #1;
    issue_latency = 3'd1;
    stalls = 0;
    fired  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (issue_fire) begin
        fired = 1'b1;
        break;
      end
      if (issue_stall) stalls++;
      @(posedge clk);
      #1;
    end
    chk("seq_fire_within_bound", 1002, 64'(fired), 64'd1);
    chk("seq_stall_count", 1003, 64'(stalls), 64'd8);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    chk("seq_stall_cycles", 1004, 64'(stall_cycles), 64'd8);
    chk("seq_sat_stall_cycles", 1005, 64'(sat_stall_cycles), 64'd7);
    chk("seq_mask", 1006, 64'(pending_mask), 64'(b(20)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
